// File: rtl/depth2disp_pkg.sv
// depth2disp_pkg: shared FSM encoding and half-float field constants for depth2disp_conv.
package depth2disp_pkg;

    typedef enum logic [1:0] {IDLE, DECODE, DIV, DONE} state_e;

    localparam int FRAC_W   = 8;
    localparam int Q_W      = 16;
    localparam int EXP_BIAS = 15;
    localparam int MANT_W   = 10;

    localparam logic [4:0] EXP_MAX     = 5'd31;
    // Exponent at which the 11-bit significand lands unshifted on the Q8.8 grid.
    localparam logic [4:0] SHIFT_PIVOT = 5'(EXP_BIAS + MANT_W - FRAC_W);
    // First exponent whose shifted significand no longer fits in Q_W bits.
    localparam logic [4:0] SAT_EXP     = 5'(EXP_BIAS + MANT_W - FRAC_W + Q_W - MANT_W);

endpackage

// File: rtl/half2fix_88_dec.sv
// half2fix_88_dec: combinational half-float magnitude to unsigned Q8.8 divisor decoder.
// Ports: h_i exponent+mantissa fields (sign stripped), d_o Q8.8 value (saturated to all ones),
//        is_zero_o zero/denormal, is_invalid_o NaN/Inf.
module half2fix_88_dec
    import depth2disp_pkg::*;
(
    input  logic [14:0]    h_i,
    output logic [Q_W-1:0] d_o,
    output logic           is_zero_o,
    output logic           is_invalid_o
);

    logic [4:0]     e;
    logic [Q_W-1:0] sig;

    assign e   = h_i[14:10];
    assign sig = Q_W'({1'b1, h_i[MANT_W-1:0]});

    assign is_zero_o    = e == '0;
    assign is_invalid_o = e == EXP_MAX;

    always_comb
        d_o = (e == '0)          ? '0 :
              (e >= SAT_EXP)     ? '1 :
              (e >= SHIFT_PIVOT) ? sig << (e - SHIFT_PIVOT) :
                                   sig >> (SHIFT_PIVOT - e);

endmodule

// File: rtl/depth2disp_conv.sv
// depth2disp_conv: disparity = Tx / depth via iterative restoring division with valid/ready handshakes.
// Ports: clk, rst (sync active-high), clken (global enable); Tx (Q24.8), depth (Q8.8 or half),
//        depth_format, in_valid/in_ready input handshake; disp (Q8.8), disp_sat, disp_zero,
//        out_valid/out_ready output handshake.
// Build option: DEPTH2DISP_ROUND_EN rounds the quotient to nearest instead of truncating.
module depth2disp_conv #(
    parameter int FRAC_W = 8,
    parameter int TX_W   = 32,
    parameter int Q_W    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clken,
    input  logic            depth_format,
    input  logic [TX_W-1:0] Tx,
    input  logic [15:0]     depth,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [Q_W-1:0]  disp,
    output logic            disp_sat,
    output logic            disp_zero,
    output logic            out_valid,
    input  logic            out_ready
);
    import depth2disp_pkg::*;

    localparam int N_W = TX_W + FRAC_W;

    state_e          state_q, state_d;
    logic [TX_W-1:0] tx_q, tx_d;
    logic [15:0]     depth_q, depth_d, d_q, d_d, r_q, r_d, r_next;
    logic            fmt_q, fmt_d, sat_q, sat_d, zero_q, zero_d;
    logic [Q_W-1:0]  quo_q, quo_d, disp_q, disp_d, q_next;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     half_d, dec_d;
    logic            half_zero, half_inv, dec_bad, ge;
    logic [N_W-1:0]  n_full;
    logic [16:0]     r_shift, q_rnd;

    half2fix_88_dec u_dec (
        .h_i          (depth_q[14:0]),
        .d_o          (half_d),
        .is_zero_o    (half_zero),
        .is_invalid_o (half_inv)
    );

    // Dividend scaled by 2^FRAC_W so the quotient comes out directly in Q8.8.
    assign n_full  = {tx_q, FRAC_W'(0)};
    assign dec_d   = fmt_q ? half_d : depth_q;
    assign dec_bad = (fmt_q & (half_zero | half_inv)) | (dec_d == '0);

    // Partial remainder stays below d, so 16 bits hold it; the shifted value needs 17.
    assign r_shift = {r_q, n_full[cnt_q]};
    assign ge      = r_shift >= {1'b0, d_q};
    assign r_next  = ge ? 16'(r_shift - {1'b0, d_q}) : r_shift[15:0];
    assign q_next  = {quo_q[Q_W-2:0], ge};

`ifdef DEPTH2DISP_ROUND_EN
    assign q_rnd = {1'b0, q_next} + 17'({r_next, 1'b0} >= {1'b0, d_q});
`else
    assign q_rnd = {1'b0, q_next};
`endif

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        depth_d = depth_q;
        fmt_d   = fmt_q;
        d_d     = d_q;
        r_d     = r_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        sat_d   = sat_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (in_valid) begin
                tx_d    = Tx;
                depth_d = depth;
                fmt_d   = depth_format;
                state_d = DECODE;
            end
            DECODE: begin
                d_d    = dec_d;
                sat_d  = 1'b0;
                zero_d = 1'b0;
                if (dec_bad) begin
                    disp_d  = '0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else if (n_full[N_W-1:16] >= (N_W-16)'(dec_d)) begin
                    disp_d  = '1;
                    sat_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    r_d     = n_full[31:16];
                    quo_d   = '0;
                    cnt_d   = 4'd15;
                    state_d = DIV;
                end
            end
            DIV: begin
                r_d   = r_next;
                quo_d = q_next;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == '0) begin
                    disp_d  = q_rnd[16] ? '1 : q_rnd[15:0];
                    sat_d   = q_rnd[16];
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            depth_q <= '0;
            fmt_q   <= 1'b0;
            d_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            sat_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (clken) begin
            state_q <= state_d;
            tx_q    <= tx_d;
            depth_q <= depth_d;
            fmt_q   <= fmt_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            sat_q   <= sat_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE) & ~rst;
    assign disp      = disp_q;
    assign disp_sat  = sat_q;
    assign disp_zero = zero_q;

endmodule

// File: tb/tb_depth2disp_conv.sv
// tb_depth2disp_conv: directed self-checking bench for depth2disp_conv.
module tb_depth2disp_conv;

    logic        clk = 1'b0;
    logic        rst, clken, depth_format, in_valid, out_ready;
    logic [31:0] Tx;
    logic [15:0] depth;
    logic        in_ready, disp_sat, disp_zero, out_valid;
    logic [15:0] disp;
    int          cmp = 0;
    int          errs = 0;

    depth2disp_conv dut (
        .clk          (clk),
        .rst          (rst),
        .clken        (clken),
        .depth_format (depth_format),
        .Tx           (Tx),
        .depth        (depth),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .disp         (disp),
        .disp_sat     (disp_sat),
        .disp_zero    (disp_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency counts the acceptance edge as edge 1; clken is dropped for 5 edges at edge stall_at.
    task automatic run(input string tag, input logic [31:0] tx, input logic [15:0] dep, input logic fmt,
                       input logic [15:0] ed, input logic es, input logic ez, input int el, input int stall_at);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        Tx = tx;
        depth = dep;
        depth_format = fmt;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        Tx = 32'hFFFF_FFFF;
        depth = 16'hFFFF;
        depth_format = ~fmt;
        n = 1;
        while (!out_valid && n < 100) begin
            if (stall_at != 0 && n == stall_at) clken = 1'b0;
            if (stall_at != 0 && n == stall_at + 5) clken = 1'b1;
            tick();
            n++;
        end
        clken = 1'b1;
        check({tag, "_latency"}, 32'(n), 32'(el));
        check({tag, "_disp"}, 32'(disp), 32'(ed));
        check({tag, "_sat"}, 32'(disp_sat), 32'(es));
        check({tag, "_zero"}, 32'(disp_zero), 32'(ez));
        tick();
    endtask

    initial begin
        logic [15:0] exp_frac;
        int seen;
        rst = 1'b1;
        clken = 1'b1;
        depth_format = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        Tx = '0;
        depth = '0;
        tick();
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_disp", 32'(disp), 32'd0);
        check("rst_sat", 32'(disp_sat), 32'd0);
        check("rst_zero", 32'(disp_zero), 32'd0);

        // 100.0 / 10.0 with the result held under backpressure
        out_ready = 1'b0;
        run("fix10", 32'h0000_6400, 16'h0A00, 1'b0, 16'h0A00, 1'b0, 1'b0, 18, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            Tx = 32'h0000_0100;
            depth = 16'h0180;
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_disp", 32'(disp), 32'h0A00);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_no_second", 32'(out_valid), 32'd0);

        run("half10", 32'h0000_6400, 16'h4900, 1'b1, 16'h0A00, 1'b0, 1'b0, 18, 0);
        run("half1", 32'h0000_6400, 16'h3C00, 1'b1, 16'h6400, 1'b0, 1'b0, 18, 0);
        run("half_sat", 32'h0000_6400, 16'h2C00, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2, 0);
        run("fix_sat_eq", 32'h0000_6400, 16'h0064, 1'b0, 16'hFFFF, 1'b1, 1'b0, 2, 0);
        run("fix_above_sat", 32'h0000_6400, 16'h0065, 1'b0, 16'hFD77, 1'b0, 1'b0, 18, 0);
        run("fix_zero", 32'h0000_6400, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 2, 0);
        run("half_inf", 32'h0000_6400, 16'h7C00, 1'b1, 16'h0000, 1'b0, 1'b1, 2, 0);
        run("half_negzero", 32'h0000_6400, 16'h8000, 1'b1, 16'h0000, 1'b0, 1'b1, 2, 0);
        run("half_tiny", 32'h0000_6400, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1, 2, 0);
        run("half_exp23", 32'h0000_6400, 16'h5C00, 1'b1, 16'h0064, 1'b0, 1'b0, 18, 0);
`ifdef DEPTH2DISP_ROUND_EN
        exp_frac = 16'h00AB;
`else
        exp_frac = 16'h00AA;
`endif
        run("fix1p5", 32'h0000_0100, 16'h0180, 1'b0, exp_frac, 1'b0, 1'b0, 18, 0);
        run("stall", 32'h0000_6400, 16'h0A00, 1'b0, 16'h0A00, 1'b0, 1'b0, 23, 6);

        // reset in the middle of the division discards the item
        check("abort_in_ready", 32'(in_ready), 32'd1);
        Tx = 32'h0000_6400;
        depth = 16'h0A00;
        depth_format = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_disp", 32'(disp), 32'd0);
        check("abort_in_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (25) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
